// File: rtl/store_write_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_write_unit_pkg
//  Description : Shared core definitions. Load/store ALU select codes and
//                the store-unit FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package store_write_unit_pkg;

    // Load operation codes, kept alongside the store codes for decode symmetry
    localparam logic [5:0] c_ALU_LB  = 6'b001000;
    localparam logic [5:0] c_ALU_LH  = 6'b001001;
    localparam logic [5:0] c_ALU_LW  = 6'b001010;
    localparam logic [5:0] c_ALU_LBU = 6'b001100;
    localparam logic [5:0] c_ALU_LHU = 6'b001101;

    // Store operation codes
    localparam logic [5:0] c_ALU_SB  = 6'b010000;
    localparam logic [5:0] c_ALU_SH  = 6'b010001;
    localparam logic [5:0] c_ALU_SW  = 6'b010010;

    // Width of the memReady wait counter; covers MAX_WAIT up to 255
    localparam int unsigned c_WAIT_CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } store_state_e;

endpackage : store_write_unit_pkg
`default_nettype wire

// File: rtl/store_write_unit_lane_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_formatter
//  Description : Combinational store formatter. Replicates the store data
//                across byte lanes, builds byte enables and flags whether
//                the request is a recognised store and whether it is
//                misaligned for its access size.
//  Revision    : 1.0  initial release
// ============================================================================
module store_lane_formatter
    import store_write_unit_pkg::*;
(
    input  logic [5:0]  alu_sel_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  byte_en_o,
    output logic        valid_o,
    output logic        misaligned_o
);

    // Decode store type into lane-replicated data and byte enables
    always_comb begin
        wdata_o      = '0;
        byte_en_o    = 4'b0000;
        valid_o      = 1'b0;
        misaligned_o = 1'b0;
        case (alu_sel_i)
            c_ALU_SB: begin
                valid_o   = 1'b1;
                wdata_o   = {4{data_i[7:0]}};
                byte_en_o = 4'b0001 << addr_lo_i;
            end
            c_ALU_SH: begin
                valid_o      = 1'b1;
                misaligned_o = addr_lo_i[0];
                wdata_o      = {2{data_i[15:0]}};
                byte_en_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            c_ALU_SW: begin
                valid_o      = 1'b1;
                misaligned_o = |addr_lo_i;
                wdata_o      = data_i;
                byte_en_o    = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule : store_lane_formatter
`default_nettype wire

// File: rtl/store_write_unit.sv
`default_nettype none
// ============================================================================
//  Module      : store_write_unit
//  Description : Memory-stage store engine. Accepts SB/SH/SW requests,
//                drives a registered write strobe to data memory until it is
//                acknowledged or a wait limit expires, and flags misaligned
//                stores and aborted writes with one-cycle pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module store_write_unit
    import store_write_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        storeEn,
    input  logic [5:0]  aluSelect,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    input  logic        memReady,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic [3:0]  memByteEn,
    output logic        busy,
    output logic        misaligned,
    output logic        timeout
);

    // Counter value seen during the last permitted WRITE cycle
    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LAST = c_WAIT_CNT_W'(MAX_WAIT - 1);

    store_state_e            state_q, state_d;
    logic [c_WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                    memWrite_q, memWrite_d;
    logic                    busy_q, busy_d;
    logic                    misaligned_q, misaligned_d;
    logic                    timeout_q, timeout_d;
    logic [31:0]             memAddr_q, memAddr_d;
    logic [31:0]             memWData_q, memWData_d;
    logic [3:0]              memByteEn_q, memByteEn_d;

    logic [31:0]             w_fmt_wdata;
    logic [3:0]              w_fmt_be;
    logic                    w_fmt_valid;
    logic                    w_fmt_mis;

    store_lane_formatter u_fmt (
        .alu_sel_i    (aluSelect),
        .addr_lo_i    (address[1:0]),
        .data_i       (storeData),
        .wdata_o      (w_fmt_wdata),
        .byte_en_o    (w_fmt_be),
        .valid_o      (w_fmt_valid),
        .misaligned_o (w_fmt_mis)
    );

    // Next-state and next-output logic; pulses default low each cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        memWrite_d   = 1'b0;
        busy_d       = 1'b0;
        misaligned_d = 1'b0;
        timeout_d    = 1'b0;
        memAddr_d    = memAddr_q;
        memWData_d   = memWData_q;
        memByteEn_d  = memByteEn_q;
        case (state_q)
            ST_IDLE: begin
                memByteEn_d = 4'b0000;
                if (storeEn && w_fmt_valid) begin
                    if (w_fmt_mis) begin
                        misaligned_d = 1'b1;
                    end else begin
                        state_d     = ST_WRITE;
                        cnt_d       = '0;
                        memWrite_d  = 1'b1;
                        busy_d      = 1'b1;
                        memAddr_d   = {address[31:2], 2'b00};
                        memWData_d  = w_fmt_wdata;
                        memByteEn_d = w_fmt_be;
                    end
                end
            end
            ST_WRITE: begin
                if (memReady) begin
                    // Acknowledge wins even on the final permitted cycle
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    memByteEn_d = 4'b0000;
                end else if (cnt_q == c_WAIT_LAST) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    memByteEn_d = 4'b0000;
                    timeout_d   = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    memWrite_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                memByteEn_d = 4'b0000;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            memWrite_q   <= 1'b0;
            busy_q       <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            memAddr_q    <= '0;
            memWData_q   <= '0;
            memByteEn_q  <= 4'b0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            memWrite_q   <= memWrite_d;
            busy_q       <= busy_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
            memAddr_q    <= memAddr_d;
            memWData_q   <= memWData_d;
            memByteEn_q  <= memByteEn_d;
        end
    end

    assign memWrite   = memWrite_q;
    assign busy       = busy_q;
    assign misaligned = misaligned_q;
    assign timeout    = timeout_q;
    assign memAddr    = memAddr_q;
    assign memWData   = memWData_q;
    assign memByteEn  = memByteEn_q;

endmodule : store_write_unit
`default_nettype wire

// File: tb/tb_store_write_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_write_unit
//  Description : Directed self-checking bench for store_write_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_store_write_unit;

    localparam logic [5:0] c_SB = 6'b010000;
    localparam logic [5:0] c_SH = 6'b010001;
    localparam logic [5:0] c_SW = 6'b010010;

    logic        clk = 1'b0;
    logic        reset;
    logic        storeEn;
    logic [5:0]  aluSelect;
    logic [31:0] address;
    logic [31:0] storeData;
    logic        memReady;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [3:0]  memByteEn;
    logic        busy;
    logic        misaligned;
    logic        timeout;

    int n_chk = 0;
    int n_err = 0;

    store_write_unit #(.MAX_WAIT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .storeEn    (storeEn),
        .aluSelect  (aluSelect),
        .address    (address),
        .storeData  (storeData),
        .memReady   (memReady),
        .memWrite   (memWrite),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memByteEn  (memByteEn),
        .busy       (busy),
        .misaligned (misaligned),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the active edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".memWrite"}, 32'(memWrite), 32'd0);
        check_val({tag, ".busy"},     32'(busy),     32'd0);
        check_val({tag, ".byteEn"},   32'(memByteEn), 32'd0);
    endtask

    task automatic check_write(input string tag, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be);
        check_val({tag, ".memWrite"}, 32'(memWrite), 32'd1);
        check_val({tag, ".busy"},     32'(busy),     32'd1);
        check_val({tag, ".addr"},     memAddr,       a);
        check_val({tag, ".wdata"},    memWData,      d);
        check_val({tag, ".byteEn"},   32'(memByteEn), 32'(be));
    endtask

    task automatic request(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        storeEn   = 1'b1;
        aluSelect = op;
        address   = a;
        storeData = d;
        tick();
        storeEn   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; storeEn = 1'b0; aluSelect = '0; address = '0;
        storeData = '0; memReady = 1'b0;
        tick(); tick();
        check_idle("rst");
        check_val("rst.addr",  memAddr,  32'h0);
        check_val("rst.wdata", memWData, 32'h0);
        check_val("rst.mis",   32'(misaligned), 32'd0);
        check_val("rst.tmo",   32'(timeout),    32'd0);
        reset = 1'b0;

        // SB to top byte lane, acknowledged on first WRITE cycle
        memReady = 1'b1;                       // ignored while idle
        tick();
        check_idle("idle_rdy");
        memReady = 1'b0;
        request(c_SB, 32'h0000_1003, 32'hDEAD_BEEF);
        check_write("sb", 32'h0000_1000, 32'hEFEF_EFEF, 4'b1000);
        memReady = 1'b1;
        tick();
        memReady = 1'b0;
        check_idle("sb_done");
        check_val("sb_hold.wdata", memWData, 32'hEFEF_EFEF);
        check_val("sb_hold.addr",  memAddr,  32'h0000_1000);

        // SH upper half, ack after 3 wait cycles; new request held under busy
        request(c_SH, 32'h0000_2002, 32'h0000_CAFE);
        storeEn = 1'b1; aluSelect = c_SW; address = 32'h0000_2F00; storeData = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            check_write($sformatf("sh_c%0d", i), 32'h0000_2000, 32'hCAFE_CAFE, 4'b1100);
            if (i == 3) begin
                memReady = 1'b1;
                storeEn  = 1'b0;
            end
            tick();
        end
        memReady = 1'b0;
        check_idle("sh_done");

        // SH lower half and SB lane 1 byte enables
        request(c_SH, 32'h0000_2000, 32'h0000_1234);
        check_write("sh_lo", 32'h0000_2000, 32'h1234_1234, 4'b0011);
        memReady = 1'b1; tick(); memReady = 1'b0;
        request(c_SB, 32'h0000_2001, 32'h0000_0077);
        check_write("sb_l1", 32'h0000_2000, 32'h7777_7777, 4'b0010);
        memReady = 1'b1; tick(); memReady = 1'b0;

        // Misaligned SW and SH
        request(c_SW, 32'h0000_3001, 32'h0BAD_F00D);
        check_idle("sw_mis");
        check_val("sw_mis.pulse", 32'(misaligned), 32'd1);
        tick();
        check_idle("sw_mis2");
        check_val("sw_mis.end", 32'(misaligned), 32'd0);
        request(c_SH, 32'h0000_3003, 32'h0000_5555);
        check_val("sh_mis.pulse", 32'(misaligned), 32'd1);
        check_val("sh_mis.busy",  32'(busy), 32'd0);
        tick();

        // Timeout: memReady held low for the full wait budget
        request(c_SW, 32'h0000_4000, 32'h1234_5678);
        for (int i = 0; i < 15; i++) begin
            check_val($sformatf("tmo_w%0d", i), 32'(memWrite), 32'd1);
            check_val($sformatf("tmo_t%0d", i), 32'(timeout),  32'd0);
            tick();
        end
        check_idle("tmo_end");
        check_val("tmo.pulse", 32'(timeout), 32'd1);
        tick();
        check_val("tmo.clear", 32'(timeout), 32'd0);

        // Ack arriving on the last permitted cycle beats the timeout
        request(c_SW, 32'h0000_4100, 32'hA5A5_5A5A);
        for (int i = 0; i < 14; i++) tick();
        check_write("race", 32'h0000_4100, 32'hA5A5_5A5A, 4'b1111);
        memReady = 1'b1; tick(); memReady = 1'b0;
        check_idle("race_end");
        check_val("race.tmo", 32'(timeout), 32'd0);

        // Reset in the second WRITE cycle, then immediate new SB
        request(c_SB, 32'h0000_5001, 32'h0000_00A5);
        tick();
        check_write("pre_rst", 32'h0000_5000, 32'hA5A5_A5A5, 4'b0010);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("mid_rst");
        check_val("mid_rst.addr",  memAddr,  32'h0);
        check_val("mid_rst.wdata", memWData, 32'h0);
        request(c_SB, 32'h0000_6002, 32'h0000_003C);
        check_write("post_rst", 32'h0000_6000, 32'h3C3C_3C3C, 4'b0100);
        memReady = 1'b1; tick(); memReady = 1'b0;

        // Unrecognised select code is ignored
        request(6'b001011, 32'h0000_7000, 32'hFFFF_FFFF);
        check_idle("bad_op");
        check_val("bad_op.mis", 32'(misaligned), 32'd0);
        check_val("bad_op.tmo", 32'(timeout),    32'd0);
        tick();
        check_idle("bad_op2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_store_write_unit
`default_nettype wire
